// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use bubbles,
// taken-branch flushes and data-memory miss holds, plus saturating event counters.
module hazard_ctrl #(
    parameter int BR_FLUSH    = 2,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pcwrite,
    output logic             fdwrite,
    output logic             flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             memerr
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd2,
        MEMWAIT = 2'd3
    } state_t;

    localparam int WW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TO_V = WW'(MEM_TIMEOUT);
    localparam logic [2:0]    BR_LOAD = 3'(BR_FLUSH - 1);

    state_t        cur;
    state_t        nxt;
    logic          pend;
    logic          pend_nxt;
    logic [2:0]    fcnt;
    logic [2:0]    fcnt_nxt;
    logic [WW-1:0] wcnt;
    logic [WW-1:0] wcnt_nxt;
    logic          br_evt;
    logic          lu;
    logic          miss;

    assign lu = ex_memread && (ex_rd != 5'd0) &&
                ((id_use1 && (id_rs1 == ex_rd)) || (id_use2 && (id_rs2 == ex_rd)));
    assign miss  = mem_req && !mem_ready;
    assign state = cur;

    // Fixed priority miss > branch > load-use; a miss freezes any flush countdown.
    always_comb begin
        pcwrite     = 1'b1;
        fdwrite     = 1'b1;
        flush       = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        nxt         = cur;
        pend_nxt    = pend;
        fcnt_nxt    = fcnt;
        br_evt      = 1'b0;
        if (!rst_n) begin
            pcwrite     = 1'b0;
            fdwrite     = 1'b0;
            flush       = 1'b1;
            idex_bubble = 1'b1;
            nxt         = RUN;
            pend_nxt    = 1'b0;
            fcnt_nxt    = 3'd0;
        end else if (miss) begin
            pcwrite   = 1'b0;
            fdwrite   = 1'b0;
            pipe_hold = 1'b1;
            nxt       = MEMWAIT;
            if (br_taken && (cur != FLUSH)) begin
                pend_nxt = 1'b1;
            end
        end else if (cur == FLUSH) begin
            fdwrite     = 1'b0;
            flush       = 1'b1;
            idex_bubble = 1'b1;
            if (fcnt <= 3'd1) begin
                nxt      = RUN;
                fcnt_nxt = 3'd0;
            end else begin
                fcnt_nxt = fcnt - 3'd1;
            end
        end else begin
            nxt = (fcnt != 3'd0) ? FLUSH : RUN;
            if (pend || br_taken) begin
                fdwrite     = 1'b0;
                flush       = 1'b1;
                idex_bubble = 1'b1;
                br_evt      = 1'b1;
                pend_nxt    = 1'b0;
                if (BR_FLUSH > 1) begin
                    fcnt_nxt = BR_LOAD;
                    nxt      = FLUSH;
                end else begin
                    fcnt_nxt = 3'd0;
                    nxt      = RUN;
                end
            end else if (lu) begin
                pcwrite     = 1'b0;
                fdwrite     = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    // Wait counter equals the index of the MEMWAIT cycle being entered.
    always_comb begin
        wcnt_nxt = '0;
        if (nxt == MEMWAIT) begin
            wcnt_nxt = (wcnt == TO_V) ? wcnt : wcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur       <= RUN;
            pend      <= 1'b0;
            fcnt      <= 3'd0;
            wcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            memerr    <= 1'b0;
        end else begin
            cur  <= nxt;
            pend <= pend_nxt;
            fcnt <= fcnt_nxt;
            wcnt <= wcnt_nxt;
            if ((MEM_TIMEOUT != 0) && (nxt == MEMWAIT) && (wcnt_nxt == TO_V)) begin
                memerr <= 1'b1;
            end
            if (!pcwrite && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (br_evt && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two parameterisations driven in lockstep
// and compared every cycle against a cycle-level behavioural model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use1, id_use2, ex_memread, br_taken, mem_req, mem_ready;

    logic        a_pcw, a_fdw, a_fl, a_bub, a_hold, a_err;
    logic [1:0]  a_st;
    logic [15:0] a_sc, a_fc;
    logic        b_pcw, b_fdw, b_fl, b_bub, b_hold, b_err;
    logic [1:0]  b_st;
    logic [3:0]  b_sc, b_fc;

    hazard_ctrl #(.BR_FLUSH(2), .CNT_W(16), .MEM_TIMEOUT(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pcwrite(a_pcw), .fdwrite(a_fdw), .flush(a_fl), .idex_bubble(a_bub),
        .pipe_hold(a_hold), .state(a_st), .stall_cnt(a_sc), .flush_cnt(a_fc),
        .memerr(a_err)
    );

    hazard_ctrl #(.BR_FLUSH(3), .CNT_W(4), .MEM_TIMEOUT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use1(id_use1), .id_use2(id_use2), .ex_memread(ex_memread), .ex_rd(ex_rd),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pcwrite(b_pcw), .fdwrite(b_fdw), .flush(b_fl), .idex_bubble(b_bub),
        .pipe_hold(b_hold), .state(b_st), .stall_cnt(b_sc), .flush_cnt(b_fc),
        .memerr(b_err)
    );

    int checks = 0;
    int errors = 0;

    int p_br[2] = '{2, 3};
    int p_w[2]  = '{16, 4};
    int p_to[2] = '{3, 0};

    // Model: waiting on memory, remaining flush cycles, pending branch, wait length.
    bit m_wait[2];
    int m_left[2];
    bit m_pend[2];
    int m_wlen[2];
    int m_stall[2];
    int m_flush[2];
    bit m_err[2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input bit u1, input bit u2, input bit mr, input logic [4:0] rd,
                                 input bit br, input bit req, input bit rdy);
        rst_n      = r;
        id_rs1     = rs1;
        id_rs2     = rs2;
        id_use1    = u1;
        id_use2    = u2;
        ex_memread = mr;
        ex_rd      = rd;
        br_taken   = br;
        mem_req    = req;
        mem_ready  = rdy;
    endtask

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v + 1 > mx) ? mx : v + 1;
    endfunction

    task automatic checkInst(input int k, input string nm,
                             input logic pcw, input logic fdw, input logic fl,
                             input logic bub, input logic hold, input logic [1:0] st,
                             input logic [31:0] sc, input logic [31:0] fc, input logic err);
        bit lu, miss, in_fl, is_br;
        logic [4:0] e;
        int e_st;
        lu    = ex_memread && (ex_rd != 0) &&
                ((id_use1 && id_rs1 == ex_rd) || (id_use2 && id_rs2 == ex_rd));
        miss  = mem_req && !mem_ready;
        in_fl = (m_left[k] > 0) && !m_wait[k];
        is_br = 1'b0;
        e_st  = m_wait[k] ? 3 : (m_left[k] > 0 ? 2 : 0);
        // e = {pcwrite, fdwrite, flush, idex_bubble, pipe_hold}
        if (!rst_n)                     e = 5'b00110;
        else if (miss)                  e = 5'b00001;
        else if (in_fl)                 e = 5'b10110;
        else if (m_pend[k] || br_taken) begin e = 5'b10110; is_br = 1'b1; end
        else if (lu)                    e = 5'b00010;
        else                            e = 5'b11000;

        checkOutput({nm, ".state"},     32'(st),  32'(e_st));
        checkOutput({nm, ".stall_cnt"}, sc,       32'(m_stall[k]));
        checkOutput({nm, ".flush_cnt"}, fc,       32'(m_flush[k]));
        checkOutput({nm, ".memerr"},    32'(err), 32'(m_err[k]));
        checkOutput({nm, ".ctrl"},      32'({pcw, fdw, fl, bub, hold}), 32'(e));

        if (!rst_n) begin
            m_wait[k] = 0; m_left[k] = 0; m_pend[k] = 0; m_wlen[k] = 0;
            m_stall[k] = 0; m_flush[k] = 0; m_err[k] = 0;
        end else if (miss) begin
            if (!in_fl && br_taken) m_pend[k] = 1;
            m_wait[k] = 1;
            m_wlen[k]++;
            if (p_to[k] != 0 && m_wlen[k] == p_to[k]) m_err[k] = 1;
            m_stall[k] = sat(m_stall[k], p_w[k]);
        end else if (in_fl) begin
            m_left[k]--;
        end else begin
            m_wait[k] = 0;
            m_wlen[k] = 0;
            if (is_br) begin
                m_flush[k] = sat(m_flush[k], p_w[k]);
                m_pend[k]  = 0;
                m_left[k]  = p_br[k] - 1;
            end else if (lu) begin
                m_stall[k] = sat(m_stall[k], p_w[k]);
            end
        end
    endtask

    task automatic tick(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit u1, input bit u2, input bit mr, input logic [4:0] rd,
                        input bit br, input bit req, input bit rdy);
        applyStimulus(r, rs1, rs2, u1, u2, mr, rd, br, req, rdy);
        @(negedge clk);
        checkInst(0, "a", a_pcw, a_fdw, a_fl, a_bub, a_hold, a_st, 32'(a_sc), 32'(a_fc), a_err);
        checkInst(1, "b", b_pcw, b_fdw, b_fl, b_bub, b_hold, b_st, 32'(b_sc), 32'(b_fc), b_err);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit r, fl, req;
        for (int k = 0; k < 2; k++) begin
            m_wait[k] = 0; m_left[k] = 0; m_pend[k] = 0; m_wlen[k] = 0;
            m_stall[k] = 0; m_flush[k] = 0; m_err[k] = 0;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_state", 32'(a_st), 32'd0);
        checkOutput("reset_stall", 32'(a_sc), 32'd0);

        $display("[TB] load-use");
        tick(1, 0, 5, 0, 1, 1, 5, 0, 0, 0);
        idle(1);
        checkOutput("lu_stall_cnt", 32'(a_sc), 32'd1);
        tick(1, 0, 0, 1, 1, 1, 0, 0, 0, 0);
        idle(1);
        checkOutput("lu_rd0_stall_cnt", 32'(a_sc), 32'd1);

        $display("[TB] branch");
        tick(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(3);
        checkOutput("br_flush_cnt", 32'(a_fc), 32'd1);
        tick(1, 7, 0, 1, 0, 1, 7, 1, 0, 0);
        tick(1, 7, 0, 1, 0, 1, 7, 0, 0, 0);
        idle(3);
        checkOutput("br_lu_stall_cnt", 32'(a_sc), 32'd1);
        checkOutput("br_lu_flush_cnt", 32'(a_fc), 32'd2);

        $display("[TB] miss");
        repeat (4) tick(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput("miss_stall_cnt", 32'(a_sc), 32'd5);
        checkOutput("miss_state_run", 32'(a_st), 32'd0);
        idle(1);

        $display("[TB] miss with branch");
        tick(1, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        repeat (2) tick(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(3);
        checkOutput("miss_br_flush_cnt", 32'(a_fc), 32'd3);

        $display("[TB] timeout and reset mid-wait");
        repeat (3) tick(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("timeout_memerr", 32'(a_err), 32'd1);
        tick(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("rst_state", 32'(a_st), 32'd0);
        checkOutput("rst_stall", 32'(a_sc), 32'd0);
        checkOutput("rst_flush", 32'(a_fc), 32'd0);
        checkOutput("rst_memerr", 32'(a_err), 32'd0);

        $display("[TB] saturation");
        for (int i = 0; i < 20; i++) begin
            tick(1, 9, 0, 1, 0, 1, 9, 0, 0, 0);
            idle(1);
        end
        checkOutput("sat_stall_b", 32'(b_sc), 32'd15);
        checkOutput("sat_stall_a", 32'(a_sc), 32'd20);

        $display("[TB] random");
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 49) != 0);
            fl  = ((m_left[0] > 0) && !m_wait[0]) || ((m_left[1] > 0) && !m_wait[1]);
            req = !fl && ($urandom_range(0, 9) < 3);
            tick(r, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0), req, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
